// File: rtl/fetch_ctrl_pkg.sv
// Shared defaults and state encoding for the instruction fetch controller.
package fetch_ctrl_pkg;

  localparam int         MEM_SPACE_DEF = 8;
  localparam int         ISIZE_DEF     = 16;
  localparam int         BOOT_ADDR_DEF = 0;
  localparam logic [3:0] OP_HALT_DEF   = 4'hF;
  localparam int         CNT_W         = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt <= '0;
    else if (clr)             cnt <= '0;
    else if (inc && !(&cnt))  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives I-memory address, presents the returned
// word to decode, and handles stall, redirect and halt.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int         MEM_SPACE = MEM_SPACE_DEF,
  parameter int         ISIZE     = ISIZE_DEF,
  parameter int         BOOT_ADDR = BOOT_ADDR_DEF,
  parameter logic [3:0] OP_HALT   = OP_HALT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [MEM_SPACE-1:0] redirect_pc,
  output logic [MEM_SPACE-1:0] imem_addr,
  input  logic [ISIZE-1:0]     imem_data,
  output logic [ISIZE-1:0]     instr,
  output logic [MEM_SPACE-1:0] instr_pc,
  output logic                 instr_valid,
  output logic                 halted,
  output logic [CNT_W-1:0]     fetch_cnt,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam logic [MEM_SPACE-1:0] BOOT = BOOT_ADDR[MEM_SPACE-1:0];

  fetch_state_t         state, state_nxt;
  logic [MEM_SPACE-1:0] pc_f, addr_nxt;
  logic                 is_halt;

  assign is_halt   = (imem_data[ISIZE-1 -: 4] == OP_HALT);
  assign instr     = imem_data;
  assign instr_pc  = pc_f;
  assign imem_addr = addr_nxt;

  // Re-reading pc_f on stall/halt keeps the presented word stable next cycle.
  always_comb begin
    addr_nxt  = BOOT;
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        addr_nxt = BOOT;
        if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (redirect)     addr_nxt = redirect_pc;
        else if (stall)   addr_nxt = pc_f;
        else if (is_halt) begin
          addr_nxt  = pc_f;
          state_nxt = ST_HALTED;
        end
        else              addr_nxt = pc_f + 1'b1;
      end
      ST_HALTED: begin
        addr_nxt = pc_f;
        if (redirect) begin
          addr_nxt  = redirect_pc;
          state_nxt = ST_RUN;
        end
      end
      default: begin
        addr_nxt  = BOOT;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc_f        <= BOOT;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc_f        <= addr_nxt;
      instr_valid <= (state_nxt == ST_RUN);
      halted      <= (state_nxt == ST_HALTED);
    end
  end

  // A redirect kills the presented word, so it is neither a fetch nor a stall.
  logic fetch_inc, stall_inc;
  assign fetch_inc = instr_valid & ~stall & ~redirect;
  assign stall_inc = instr_valid &  stall & ~redirect;

  sat_counter #(.W(CNT_W)) u_fetch_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (fetch_inc),
    .cnt (fetch_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (stall_inc),
    .cnt (stall_cnt)
  );

endmodule
